// File: rtl/ddr3_return_drain.sv
// ddr3_return_drain
// Drains the controller's return-data FIFO ({addr, data}) into a 2-entry
// skid buffer and presents the words to the host as a valid/ready stream.
// Also tags the last beat of each burst and counts the words handed over.
// Optional build macro: DRAIN_SEQCHK_EN adds a sticky address-sequence
// checker (seq_err). Without it seq_err is tied 0 and no checker exists.
module ddr3_return_drain #(
    parameter int BURST_LEN = 8,
    parameter int AW        = 26,
    parameter int DW        = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ret_notempty,
    input  logic [AW+DW-1:0]   ret_data,
    output logic               ret_get,
    input  logic               host_ready,
    output logic               validout,
    output logic [DW-1:0]      dout,
    output logic [AW-1:0]      raddr,
    output logic               rlast,
    output logic [CNT_W-1:0]   drained_cnt,
    output logic               seq_err
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int EW = AW + DW;

    // occ: words held in the skid buffer; inflight: a word popped last cycle
    // whose data is on ret_data now and is captured at the coming edge.
    logic [1:0]    occ;
    logic          inflight;
    logic [EW-1:0] head_q;
    logic [EW-1:0] tail_q;
    logic [BW-1:0] beat;
    logic          accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept   = validout & host_ready;
    assign validout = (occ != 2'd0);
    assign dout     = head_q[DW-1:0];
    assign raddr    = head_q[EW-1:DW];
    assign rlast    = validout & (beat == BW'(BURST_LEN - 1));

    // Pop credit: buffered + in-flight words must stay within the two slots.
    // An accept this cycle frees a slot at the same edge, which is what keeps
    // the stream at one word per cycle while the host is ready.
    always_comb begin
        ret_get = 1'b0;
        if (!reset && ret_notempty &&
            (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, accept})))
            ret_get = 1'b1;
    end

    // Skid buffer: capture the in-flight word at the tail, pop head on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            inflight <= ret_get;
            case (occ)
                2'd0: begin
                    if (inflight) begin
                        head_q <= ret_data;
                        occ    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && inflight) begin
                        head_q <= ret_data;
                    end else if (accept) begin
                        occ <= 2'd0;
                    end else if (inflight) begin
                        tail_q <= ret_data;
                        occ    <= 2'd2;
                    end
                end
                default: begin
                    if (accept) begin
                        head_q <= tail_q;
                        if (inflight)
                            tail_q <= ret_data;
                        else
                            occ <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Beat position within the burst and saturating drained-word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat        <= '0;
            drained_cnt <= '0;
        end else if (accept) begin
            beat        <= beat + BW'(1);
            drained_cnt <= sat_inc(drained_cnt);
        end
    end

`ifdef DRAIN_SEQCHK_EN
    logic [AW-1:0] prev_addr;
    logic          seq_err_q;

    // Burst starts must be burst-aligned; later beats must follow the
    // previous accepted address by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_addr <= '0;
            seq_err_q <= 1'b0;
        end else if (accept) begin
            prev_addr <= raddr;
            if (beat == '0) begin
                if (raddr[BW-1:0] != '0)
                    seq_err_q <= 1'b1;
            end else if (raddr != prev_addr + AW'(1)) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_return_drain.sv
// Directed bench for ddr3_return_drain: behavioural return FIFO plus an
// in-order scoreboard with a burst-beat model for rlast.
module tb_ddr3_return_drain;

    logic        clk;
    logic        reset;
    logic        ret_notempty;
    logic [41:0] ret_data;
    logic        ret_get;
    logic        host_ready;
    logic        validout;
    logic [15:0] dout;
    logic [25:0] raddr;
    logic        rlast;
    logic [15:0] drained_cnt;
    logic        seq_err;

`ifdef DRAIN_SEQCHK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    ddr3_return_drain dut (
        .clk          (clk),
        .reset        (reset),
        .ret_notempty (ret_notempty),
        .ret_data     (ret_data),
        .ret_get      (ret_get),
        .host_ready   (host_ready),
        .validout     (validout),
        .dout         (dout),
        .raddr        (raddr),
        .rlast        (rlast),
        .drained_cnt  (drained_cnt),
        .seq_err      (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [41:0] fifo_q[$];
    logic [41:0] exp_q[$];
    logic        rst_drv;
    logic        get_s;
    int checks, errors;
    int cyc_n, n_get, n_acc, first_get, first_vld, first_acc, last_acc;
    int mbeat, outst, max_outst;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [25:0] a, input logic [15:0] d);
        fifo_q.push_back({a, d});
        exp_q.push_back({a, d});
    endtask

    task automatic clr_stats();
        n_get = 0; n_acc = 0;
        first_get = -1; first_vld = -1; first_acc = -1; last_acc = -1;
    endtask

    // One clock: drive inputs just after the edge, sample and score at negedge.
    task automatic cyc(input logic hr);
        logic [41:0] e;
        @(posedge clk);
        #1;
        reset = rst_drv;
        if (get_s && fifo_q.size() != 0) ret_data = fifo_q.pop_front();
        ret_notempty = (fifo_q.size() != 0);
        host_ready = hr;
        @(negedge clk);
        cyc_n++;
        get_s = ret_get;
        if (get_s) begin
            n_get++;
            if (first_get < 0) first_get = cyc_n;
        end
        if (validout && first_vld < 0) first_vld = cyc_n;
        if (reset) begin
            outst = 0; mbeat = 0; exp_q.delete();
        end else begin
            if (validout && host_ready) begin
                n_acc++;
                last_acc = cyc_n;
                if (first_acc < 0) first_acc = cyc_n;
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 64'(raddr), 64'h3ffffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("raddr", 64'(raddr), 64'(e[41:16]));
                    chk("dout", 64'(dout), 64'(e[15:0]));
                    chk("rlast", 64'(rlast), 64'(mbeat == 7));
                    mbeat = (mbeat + 1) % 8;
                end
                outst = outst - 1;
            end
            if (get_s) outst = outst + 1;
            if (outst > max_outst) max_outst = outst;
        end
    endtask

    task automatic reset_dut();
        rst_drv = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        rst_drv = 1'b0;
        clr_stats();
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && n_acc < n; i++) cyc(1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc_n = 0;
        mbeat = 0; outst = 0; max_outst = 0;
        reset = 1'b1; rst_drv = 1'b1; host_ready = 1'b0;
        ret_notempty = 1'b0; ret_data = '0; get_s = 1'b0;
        clr_stats();

        // Reset state, with the FIFO non-empty to show ret_get stays low
        push(26'h7, 16'h1234);
        cyc(1'b0);
        cyc(1'b0);
        chk("rst_ret_get", 64'(ret_get), 0);
        chk("rst_validout", 64'(validout), 0);
        chk("rst_dout", 64'(dout), 0);
        chk("rst_raddr", 64'(raddr), 0);
        chk("rst_rlast", 64'(rlast), 0);
        chk("rst_cnt", 64'(drained_cnt), 0);
        chk("rst_seq_err", 64'(seq_err), 0);
        fifo_q.delete(); exp_q.delete();
        rst_drv = 1'b0;
        clr_stats();

        // 1: one aligned burst streamed with host always ready
        for (int i = 0; i < 8; i++) push(26'h40 + 26'(i), 16'hA000 + 16'(i));
        run_until(8, 40);
        cyc(1'b1);
        chk("t1_latency", 64'(first_vld - first_get), 2);
        chk("t1_back_to_back", 64'(last_acc - first_acc), 7);
        chk("t1_words", 64'(n_acc), 8);
        chk("t1_cnt", 64'(drained_cnt), 8);
        chk("t1_idle_vld", 64'(validout), 0);
        chk("t1_seq_err", 64'(seq_err), 0);

        // 2: backpressure holds two words, head stable
        clr_stats();
        for (int i = 0; i < 4; i++) push(26'h100 + 26'(i), 16'hB000 + 16'(i));
        for (int i = 0; i < 5; i++) cyc(1'b0);
        chk("t2_mid_raddr", 64'(raddr), 64'h100);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        chk("t2_gets", 64'(n_get), 2);
        chk("t2_vld", 64'(validout), 1);
        chk("t2_head_raddr", 64'(raddr), 64'h100);
        chk("t2_head_dout", 64'(dout), 64'hB000);
        run_until(4, 30);
        cyc(1'b1);
        chk("t2_total_gets", 64'(n_get), 4);
        chk("t2_left", 64'(exp_q.size()), 0);
        chk("t2_cnt", 64'(drained_cnt), 12);

        // 3: 64 words with random host_ready
        reset_dut();
        max_outst = 0;
        for (int i = 0; i < 64; i++) push(26'h200 + 26'(i), 16'($urandom));
        for (int i = 0; i < 800 && n_acc < 64; i++) cyc(1'($urandom_range(0, 1)));
        cyc(1'b1);
        chk("t3_words", 64'(n_acc), 64);
        chk("t3_left", 64'(exp_q.size()), 0);
        chk("t3_occ_le_2", 64'(max_outst <= 2), 1);
        chk("t3_cnt", 64'(drained_cnt), 64);

        // 4: FIFO runs dry after beat 3, burst resumes 5 cycles later
        reset_dut();
        for (int i = 0; i < 4; i++) push(26'h300 + 26'(i), 16'hC000 + 16'(i));
        run_until(4, 30);
        cyc(1'b1);
        cyc(1'b1);
        chk("t4_gap_vld", 64'(validout), 0);
        chk("t4_gap_rlast", 64'(rlast), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1);
        for (int i = 4; i < 8; i++) push(26'h300 + 26'(i), 16'hC000 + 16'(i));
        run_until(8, 30);
        cyc(1'b1);
        chk("t4_words", 64'(n_acc), 8);
        chk("t4_cnt", 64'(drained_cnt), 8);
        chk("t4_seq_err", 64'(seq_err), 0);

        // 5: reset with one word buffered and one in flight
        reset_dut();
        push(26'h500, 16'hD000);
        push(26'h501, 16'hD001);
        cyc(1'b0);
        cyc(1'b0);
        rst_drv = 1'b1;
        cyc(1'b0);
        chk("t5_pre_vld", 64'(validout), 1);
        chk("t5_pre_raddr", 64'(raddr), 64'h500);
        rst_drv = 1'b0;
        clr_stats();
        cyc(1'b1);
        chk("t5_vld", 64'(validout), 0);
        chk("t5_dout", 64'(dout), 0);
        chk("t5_raddr", 64'(raddr), 0);
        chk("t5_rlast", 64'(rlast), 0);
        chk("t5_ret_get", 64'(ret_get), 0);
        chk("t5_cnt", 64'(drained_cnt), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1);
        chk("t5_no_ghost", 64'(first_vld < 0), 1);

        // 6: address sequence checker
        reset_dut();
        chk("t6_seq_clear", 64'(seq_err), 0);
        push(26'h80, 16'hE000);
        push(26'h81, 16'hE001);
        push(26'h83, 16'hE003);
        run_until(3, 20);
        cyc(1'b1);
        chk("t6_seq_gap", 64'(seq_err), 64'(SEQ_EXP));
        for (int i = 0; i < 3; i++) cyc(1'b1);
        chk("t6_seq_sticky", 64'(seq_err), 64'(SEQ_EXP));
        reset_dut();
        chk("t6_seq_reset", 64'(seq_err), 0);
        push(26'h81, 16'hE101);
        run_until(1, 20);
        cyc(1'b1);
        chk("t6_seq_unaligned", 64'(seq_err), 64'(SEQ_EXP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
